multdiv_sched: RTL and testbench
================================

# multdiv_sched

Sequencing and writeback-arbitration controller for the iterative multiply/divide unit in the 5-stage pipeline. Accepts a mul/div issue from the DX stage, latches operands, pulses the unit's start, and tracks the in-flight destination for hazard stalls. It captures the result or exception and shares the single regfile write port with the MW-stage writeback. On an exception it writes the ISA status code to $r30 ($rstatus).

## Interface
- MAX_WAIT, 2, cycles a captured result may wait for the write port before it forces the port.
- clock  in  1  master clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- issue_valid  in  1  DX holds mul or div
- issue_is_div  in  1  1 = div, 0 = mul
- issue_a, issue_b  in  32  bypassed ALU operands
- issue_rd  in  5  destination register
- issue_stall  out  1  issue not accepted; freeze PC/FD/DX
- md_start  out  1  one-cycle start pulse to multdiv unit
- md_is_div  out  1  held op type (ctrl_div vs ctrl_mult)
- md_a, md_b  out  32  held operands
- md_ready  in  1  unit result valid
- md_result  in  32  unit result
- md_exception  in  1  unit overflow / divide-by-zero
- dep_rs_a, dep_rs_b  in  5  FD-stage source registers
- hazard  out  1  FD source depends on in-flight result
- pipe_we  in  1  MW writeback enable
- pipe_wreg  in  5  MW destination
- pipe_wdata  in  32  MW data
- mw_hold  out  1  MW must hold its instruction this cycle
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  5  regfile write register
- data_writeReg  out  32  regfile write data
- fwd_valid  out  1  forwarding data valid (MDSCHED_FWD_EN only; else tied 0)
- fwd_data  out  32  forwarded result

## Operation
- States: IDLE, BUSY, WB.
- IDLE: issue_stall = 0. On issue_valid, latch a, b, op and rd, then go to BUSY.
- BUSY: md_start = 1 in the first BUSY cycle only. On md_ready = 1, capture the result, exception, op and rd, clear wait_cnt and go to WB. In every other state, md_ready is ignored.
- Suppressed write: if the captured rd = 0 and there is no exception, go BUSY -> IDLE with no write.
- WB: the target register and data are fixed at capture:
  - exception: reg 30, data 4 (mul) or 5 (div);
  - otherwise: reg rd, data md_result.
- WB write-port arbitration:
  - pipe_we = 0: this block drives the port and goes to IDLE.
  - pipe_we = 1 and wait_cnt < MAX_WAIT: the port passes the pipe write and wait_cnt increments.
  - pipe_we = 1 and wait_cnt = MAX_WAIT: this block drives the port, mw_hold = 1 and the state goes to IDLE.
- issue_stall = issue_valid & (state != IDLE).
- hazard = 1 in BUSY or WB when the in-flight rd is nonzero and equals dep_rs_a or dep_rs_b. It is also 1 when either dep equals 30, since an exception could write $r30.
- Port mux when this block does not own the port: ctrl_* = pipe_*.
- wait_cnt width is clog2(MAX_WAIT+1); it saturates.

## Timing
- Reset (async) state: state = IDLE, and every output register is 0: md_start, md_is_div, md_a, md_b, fwd_valid, fwd_data, mw_hold.
- Reset mid-operation: any in-flight result is discarded, and a later md_ready is ignored because the state is IDLE.
- Issue at edge t: md_start is high in cycle t+1, and md_a/md_b are stable from t+1 until the next issue.
- Capture at edge c, where md_ready is high in cycle c-1: the earliest regfile write is cycle c and the latest is c+MAX_WAIT.
- hazard falls in the cycle after the write cycle.
- Back-to-back mul: the second issue is accepted in the cycle after the WB->IDLE transition.

## Configuration
- MDSCHED_FWD_EN defined:
  - In WB, fwd_valid = 1 and fwd_data = the captured result.
  - hazard is deasserted for rd matches in WB when there is no exception, so decode bypasses from fwd_data instead.
  - A dependence on reg 30 still stalls.
- MDSCHED_FWD_EN undefined: fwd_valid = 0, fwd_data = 0, and hazard holds through WB.

## Test plan
- mul issue a = 6, b = 7, rd = 5; md_ready after 16 cycles with result 42 -> md_start pulses once; in the next cycle the write is reg 5, data 42; then IDLE.
- div issue with md_exception = 1 -> the write is reg 30, data 5; mul with an exception -> reg 30, data 4.
- Captured result while pipe_we = 1 for 5 consecutive cycles, MAX_WAIT = 2 -> pipe writes in 2 cycles; in the third cycle the multdiv write wins and mw_hold = 1.
- BUSY with rd = 8, dep_rs_a = 8 -> hazard = 1 until the cycle after the write. With MDSCHED_FWD_EN, hazard = 0 in WB and fwd_data = the result. dep_rs_b = 30 -> hazard = 1 throughout.
- Second issue_valid while BUSY -> issue_stall = 1 and no md_start; accepted after the first result is written.
- Reset asserted mid-BUSY, then md_ready pulses -> no regfile write and all outputs 0.

Source files
------------

// File: rtl/multdiv_sched.sv
// Issue sequencing, hazard tracking and regfile write-port arbitration for the iterative mul/div unit.
// Optional forwarding of the captured result is enabled by defining MDSCHED_FWD_EN.
module multdiv_sched #(
    parameter int unsigned MAX_WAIT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    output logic        issue_stall,
    output logic        md_start,
    output logic        md_is_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic [4:0]  dep_rs_a,
    input  logic [4:0]  dep_rs_b,
    output logic        hazard,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wreg,
    input  logic [31:0] pipe_wdata,
    output logic        mw_hold,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        fwd_valid,
    output logic [31:0] fwd_data
);

    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [4:0] STATUS_REG = 5'd30;

`ifdef MDSCHED_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           start_q, start_d;
    logic           is_div_q, is_div_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [4:0]     rd_q, rd_d;
    logic           exc_q, exc_d;
    logic [4:0]     wb_reg_q, wb_reg_d;
    logic [31:0]    wb_data_q, wb_data_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           mw_hold_q, mw_hold_d;
    logic           fwd_valid_q, fwd_valid_d;
    logic [31:0]    fwd_data_q, fwd_data_d;
    logic           own_port_s;
    logic           rd_match_s;
    logic           dep_status_s;

    // Port ownership: free port, or the captured result has waited long enough to force it
    always_comb begin
        if (state_q == S_WB) begin
            own_port_s = !pipe_we || (wait_cnt_q == WAIT_MAX);
        end else begin
            own_port_s = 1'b0;
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        is_div_d    = is_div_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        exc_d       = exc_q;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        wait_cnt_d  = wait_cnt_q;
        mw_hold_d   = 1'b0;
        fwd_valid_d = fwd_valid_q;
        fwd_data_d  = fwd_data_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    is_div_d = issue_is_div;
                    a_d      = issue_a;
                    b_d      = issue_b;
                    rd_d     = issue_rd;
                    start_d  = 1'b1;
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_BUSY: begin
                if (md_ready) begin
                    exc_d      = md_exception;
                    wait_cnt_d = {CW{1'b0}};
                    if (md_exception) begin
                        wb_reg_d  = STATUS_REG;
                        wb_data_d = is_div_q ? 32'd5 : 32'd4;
                    end else begin
                        wb_reg_d  = rd_q;
                        wb_data_d = md_result;
                    end
                    // A clean result for $r0 is dropped without touching the port
                    if (!md_exception && (rd_q == 5'd0)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_WB;
                        mw_hold_d   = (WAIT_MAX == {CW{1'b0}});
                        fwd_valid_d = FWD_EN;
                        fwd_data_d  = FWD_EN ? md_result : 32'd0;
                    end
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_WB: begin
                if (own_port_s) begin
                    state_d     = S_IDLE;
                    fwd_valid_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    mw_hold_d  = (wait_cnt_d == WAIT_MAX);
                end
            end
            default: begin
                state_d     = S_IDLE;
                fwd_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            is_div_q    <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            rd_q        <= 5'd0;
            exc_q       <= 1'b0;
            wb_reg_q    <= 5'd0;
            wb_data_q   <= 32'd0;
            wait_cnt_q  <= {CW{1'b0}};
            mw_hold_q   <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            is_div_q    <= is_div_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            exc_q       <= exc_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            wait_cnt_q  <= wait_cnt_d;
            mw_hold_q   <= mw_hold_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // Hazard detection; with forwarding, a clean WB result is bypassed rather than stalled on
    always_comb begin
        rd_match_s   = (rd_q != 5'd0) && ((rd_q == dep_rs_a) || (rd_q == dep_rs_b));
        dep_status_s = (dep_rs_a == STATUS_REG) || (dep_rs_b == STATUS_REG);
        if (state_q == S_BUSY) begin
            hazard = rd_match_s || dep_status_s;
        end else if (state_q == S_WB) begin
            hazard = (rd_match_s && !(FWD_EN && !exc_q)) || dep_status_s;
        end else begin
            hazard = 1'b0;
        end
    end

    // Regfile write-port mux
    always_comb begin
        if (own_port_s) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = wb_reg_q;
            data_writeReg    = wb_data_q;
        end else begin
            ctrl_writeEnable = pipe_we;
            ctrl_writeReg    = pipe_wreg;
            data_writeReg    = pipe_wdata;
        end
    end

    assign issue_stall = issue_valid && (state_q != S_IDLE);
    assign md_start    = start_q;
    assign md_is_div   = is_div_q;
    assign md_a        = a_q;
    assign md_b        = b_q;
    assign mw_hold     = mw_hold_q && pipe_we;
    assign fwd_valid   = fwd_valid_q;
    assign fwd_data    = fwd_data_q;

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed self-checking bench for multdiv_sched (MAX_WAIT = 2).
module tb_multdiv_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_is_div;
    logic [31:0] issue_a, issue_b;
    logic [4:0]  issue_rd;
    logic        issue_stall, md_start, md_is_div;
    logic [31:0] md_a, md_b;
    logic        md_ready, md_exception;
    logic [31:0] md_result;
    logic [4:0]  dep_rs_a, dep_rs_b;
    logic        hazard;
    logic        pipe_we;
    logic [4:0]  pipe_wreg;
    logic [31:0] pipe_wdata;
    logic        mw_hold, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;

`ifdef MDSCHED_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    multdiv_sched #(.MAX_WAIT(2)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .issue_stall(issue_stall), .md_start(md_start), .md_is_div(md_is_div),
        .md_a(md_a), .md_b(md_b),
        .md_ready(md_ready), .md_result(md_result), .md_exception(md_exception),
        .dep_rs_a(dep_rs_a), .dep_rs_b(dep_rs_b), .hazard(hazard),
        .pipe_we(pipe_we), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata),
        .mw_hold(mw_hold), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        issue_valid  = 1'b1;
        issue_is_div = is_div;
        issue_a      = a;
        issue_b      = b;
        issue_rd     = rd;
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_is_div = 1'b0; issue_a = 32'd0; issue_b = 32'd0; issue_rd = 5'd0;
        md_ready = 1'b0; md_result = 32'd0; md_exception = 1'b0;
        dep_rs_a = 5'd0; dep_rs_b = 5'd0;
        pipe_we = 1'b0; pipe_wreg = 5'd0; pipe_wdata = 32'd0;
        tick(); tick();
        check_val("rst_md_start", {31'd0, md_start}, 32'd0);
        check_val("rst_md_a", md_a, 32'd0);
        check_val("rst_mw_hold", {31'd0, mw_hold}, 32'd0);
        check_val("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        reset = 1'b0;

        // mul 6*7 -> r5
        issue(1'b0, 32'd6, 32'd7, 5'd5);
        #1 check_val("idle_no_stall", {31'd0, issue_stall}, 32'd0);
        tick();
        issue_valid = 1'b0;
        dep_rs_a = 5'd5;
        #1;
        check_val("mul_start", {31'd0, md_start}, 32'd1);
        check_val("mul_a", md_a, 32'd6);
        check_val("mul_b", md_b, 32'd7);
        check_val("mul_is_div", {31'd0, md_is_div}, 32'd0);
        check_val("busy_hazard", {31'd0, hazard}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (md_start) pulses++;
        end
        check_val("start_once", pulses, 32'd0);
        check_val("mul_a_held", md_a, 32'd6);
        md_ready = 1'b1; md_result = 32'd42;
        tick();
        md_ready = 1'b0;
        #1;
        check_val("mul_we", {31'd0, ctrl_writeEnable}, 32'd1);
        check_val("mul_reg", {27'd0, ctrl_writeReg}, 32'd5);
        check_val("mul_data", data_writeReg, 32'd42);
        check_val("wb_hazard", {31'd0, hazard}, FWD ? 32'd0 : 32'd1);
        check_val("wb_fwd_valid", {31'd0, fwd_valid}, FWD ? 32'd1 : 32'd0);
        check_val("wb_fwd_data", fwd_data, FWD ? 32'd42 : 32'd0);
        tick();
        check_val("post_wb_we", {31'd0, ctrl_writeEnable}, 32'd0);
        check_val("post_wb_hazard", {31'd0, hazard}, 32'd0);
        dep_rs_a = 5'd0;

        // div exception -> r30 = 5, then mul exception -> r30 = 4
        issue(1'b1, 32'd9, 32'd0, 5'd3);
        tick();
        issue_valid = 1'b0;
        check_val("div_is_div", {31'd0, md_is_div}, 32'd1);
        md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd77;
        tick();
        md_ready = 1'b0; md_exception = 1'b0;
        #1;
        check_val("divx_we", {31'd0, ctrl_writeEnable}, 32'd1);
        check_val("divx_reg", {27'd0, ctrl_writeReg}, 32'd30);
        check_val("divx_data", data_writeReg, 32'd5);
        tick();
        issue(1'b0, 32'h7fffffff, 32'd4, 5'd6);
        tick();
        issue_valid = 1'b0;
        md_ready = 1'b1; md_exception = 1'b1;
        tick();
        md_ready = 1'b0; md_exception = 1'b0;
        #1;
        check_val("mulx_reg", {27'd0, ctrl_writeReg}, 32'd30);
        check_val("mulx_data", data_writeReg, 32'd4);
        tick();

        // pipe keeps the port busy: two pipe writes, then forced write with mw_hold
        issue(1'b0, 32'd3, 32'd5, 5'd9);
        tick();
        issue_valid = 1'b0;
        md_ready = 1'b1; md_result = 32'h1234;
        pipe_we = 1'b1; pipe_wreg = 5'd2; pipe_wdata = 32'hAA;
        tick();
        md_ready = 1'b0;
        #1;
        check_val("arb0_reg", {27'd0, ctrl_writeReg}, 32'd2);
        check_val("arb0_data", data_writeReg, 32'hAA);
        check_val("arb0_hold", {31'd0, mw_hold}, 32'd0);
        tick();
        check_val("arb1_reg", {27'd0, ctrl_writeReg}, 32'd2);
        check_val("arb1_hold", {31'd0, mw_hold}, 32'd0);
        tick();
        check_val("arb2_we", {31'd0, ctrl_writeEnable}, 32'd1);
        check_val("arb2_reg", {27'd0, ctrl_writeReg}, 32'd9);
        check_val("arb2_data", data_writeReg, 32'h1234);
        check_val("arb2_hold", {31'd0, mw_hold}, 32'd1);
        tick();
        check_val("arb3_reg", {27'd0, ctrl_writeReg}, 32'd2);
        check_val("arb3_hold", {31'd0, mw_hold}, 32'd0);
        tick();
        pipe_we = 1'b0;

        // status-register dependence, unrelated dep, and a stalled second issue
        issue(1'b0, 32'd10, 32'd2, 5'd8);
        tick();
        issue(1'b0, 32'd11, 32'd12, 5'd7);
        dep_rs_a = 5'd7; dep_rs_b = 5'd30;
        #1;
        check_val("stall_busy", {31'd0, issue_stall}, 32'd1);
        check_val("dep30_busy", {31'd0, hazard}, 32'd1);
        dep_rs_b = 5'd0;
        #1 check_val("dep_nomatch", {31'd0, hazard}, 32'd0);
        tick();
        check_val("no_second_start", {31'd0, md_start}, 32'd0);
        check_val("a_not_replaced", md_a, 32'd10);
        md_ready = 1'b1; md_result = 32'd20; dep_rs_b = 5'd30;
        tick();
        md_ready = 1'b0;
        #1;
        check_val("dep30_wb", {31'd0, hazard}, 32'd1);
        check_val("stall_wb", {31'd0, issue_stall}, 32'd1);
        check_val("first_reg", {27'd0, ctrl_writeReg}, 32'd8);
        tick();
        check_val("accept_idle", {31'd0, issue_stall}, 32'd0);
        tick();
        issue_valid = 1'b0; dep_rs_a = 5'd0; dep_rs_b = 5'd0;
        #1;
        check_val("second_start", {31'd0, md_start}, 32'd1);
        check_val("second_a", md_a, 32'd11);

        // second op targets rd=7; make it suppressed-write-free and drain it
        md_ready = 1'b1; md_result = 32'd132;
        tick();
        md_ready = 1'b0;
        #1 check_val("second_reg", {27'd0, ctrl_writeReg}, 32'd7);
        tick();

        // rd = 0 clean result: no write, straight back to IDLE
        issue(1'b0, 32'd1, 32'd1, 5'd0);
        tick();
        issue_valid = 1'b0;
        md_ready = 1'b1; md_result = 32'd1;
        tick();
        md_ready = 1'b0;
        #1 check_val("rd0_no_we", {31'd0, ctrl_writeEnable}, 32'd0);
        issue_valid = 1'b1;
        #1 check_val("rd0_idle", {31'd0, issue_stall}, 32'd0);
        issue_valid = 1'b0;
        tick();

        // reset mid-BUSY discards the operation
        issue(1'b1, 32'd50, 32'd5, 5'd4);
        tick();
        issue_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_val("mid_rst_start", {31'd0, md_start}, 32'd0);
        check_val("mid_rst_a", md_a, 32'd0);
        check_val("mid_rst_div", {31'd0, md_is_div}, 32'd0);
        tick();
        reset = 1'b0;
        md_ready = 1'b1; md_result = 32'd99; dep_rs_a = 5'd4;
        tick();
        md_ready = 1'b0;
        #1;
        check_val("rst_ready_no_we", {31'd0, ctrl_writeEnable}, 32'd0);
        check_val("rst_ready_hazard", {31'd0, hazard}, 32'd0);
        check_val("rst_ready_fwd", {31'd0, fwd_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
